vip_axi4_wr_responder: RTL

- Active AXI4 write-side subordinate for the VIP: accepts AW and W, stores data in an internal byte-strobed memory, returns B.
- Sits at the subordinate end of the write channels, where the write-channel protocol checkers observe traffic.
- Single outstanding transaction; INCR and FIXED bursts supported; errors are reported via bresp.
- A registered backdoor read port lets benches inspect memory contents.

---
 rtl/vip_axi4_pkg.sv | 31 +++
 rtl/vip_axi4_strb_mem.sv | 40 ++++
 rtl/vip_axi4_wr_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vip_axi4_pkg.sv
// Shared types and constants for the AXI4 write-side VIP responder.
package vip_axi4_pkg;

  typedef struct packed {
    int unsigned id_width;
    int unsigned addr_width;
    int unsigned data_width;
    int unsigned strb_width;
    int unsigned user_width;
  } vip_axi4_cfg_t;

  localparam logic [1:0] VIP_AXI4_RESP_OKAY_C   = 2'b00;
  localparam logic [1:0] VIP_AXI4_RESP_SLVERR_C = 2'b10;

  localparam logic [1:0] FIXED_C = 2'b00;
  localparam logic [1:0] INCR_C  = 2'b01;
  localparam logic [1:0] WRAP_C  = 2'b10;

  typedef enum logic [1:0] {
    IDLE_E,
    DATA_E,
    RESP_E
  } wr_resp_state_t;

  // A zero width field in the config means "use the VIP default width".
  function automatic int unsigned cfg_or_default(input int unsigned value,
                                                 input int unsigned dflt);
    return (value == 0) ? dflt : value;
  endfunction

endpackage

// File: rtl/vip_axi4_strb_mem.sv
// Byte-strobed single-write-port memory with a registered backdoor read port.
module vip_axi4_strb_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-enable write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Registered read; a same-cycle write to the same word returns the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/vip_axi4_wr_responder.sv
// AXI4 write-channel subordinate: accepts one AW + W burst at a time, stores
// strobed data in an internal memory and answers with a B response.
module vip_axi4_wr_responder
  import vip_axi4_pkg::*;
#(
  parameter vip_axi4_cfg_t CFG_P          = '{default: '0},
  parameter int unsigned MEM_DEPTH_P      = 256,
  parameter int unsigned AW_READY_DELAY_P = 0,
  localparam int unsigned ID_WIDTH   = cfg_or_default(CFG_P.id_width, 4),
  localparam int unsigned ADDR_WIDTH = cfg_or_default(CFG_P.addr_width, 32),
  localparam int unsigned DATA_WIDTH = cfg_or_default(CFG_P.data_width, 32),
  localparam int unsigned STRB_WIDTH = cfg_or_default(CFG_P.strb_width, DATA_WIDTH / 8),
  localparam int unsigned USER_WIDTH = cfg_or_default(CFG_P.user_width, 1),
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH_P)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic [USER_WIDTH-1:0] buser,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [IDX_W-1:0]      mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int unsigned SIZE_FULL = $clog2(STRB_WIDTH);
  // Wide enough for start index + 255 beats at any depth, so range overflow
  // is always detected rather than wrapped.
  localparam int unsigned EXT_W     = IDX_W + 9;
  localparam logic [15:0] DLY_C     = 16'(AW_READY_DELAY_P);

  wr_resp_state_t        state_q, state_d;
  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;
  logic [ID_WIDTH-1:0]   bid_d;
  logic [15:0]           dly_q, dly_d;

  logic [IDX_W:0]        idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  fixed_q, fixed_d;

  logic                  aw_hs, w_hs, b_hs;
  logic [IDX_W:0]        start_idx;
  logic [EXT_W-1:0]      end_ext;
  logic                  addr_hi_err, aw_err;
  logic                  last_by_cnt, mismatch, mem_we;
  logic                  unused_addr_lo;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign buser = '0;

  assign unused_addr_lo = ^(awaddr & ADDR_WIDTH'(STRB_WIDTH - 1));

  // Burst legality is decided once at AW time from the start word index.
  assign start_idx   = {1'b0, awaddr[SIZE_FULL +: IDX_W]};
  assign addr_hi_err = |(awaddr >> (SIZE_FULL + IDX_W));
  assign end_ext     = EXT_W'(start_idx) + ((awburst == INCR_C) ? EXT_W'(awlen) : '0);
  assign aw_err      = (awsize != 3'(SIZE_FULL)) || (awburst == WRAP_C) ||
                       (awburst == 2'b11) || addr_hi_err ||
                       (end_ext >= EXT_W'(MEM_DEPTH_P));

  // Next-state and registered-output logic for IDLE -> DATA -> RESP.
  always_comb begin
    state_d     = state_q;
    awready_d   = awready;
    wready_d    = wready;
    bvalid_d    = bvalid;
    bresp_d     = bresp;
    bid_d       = bid;
    dly_d       = dly_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fixed_d     = fixed_q;
    last_by_cnt = (cnt_q == {1'b0, len_q});
    mismatch    = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE_E: begin
        if (aw_hs) begin
          state_d   = DATA_E;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = awid;
          idx_d     = start_idx;
          len_d     = awlen;
          cnt_d     = '0;
          err_d     = aw_err;
          fixed_d   = (awburst == FIXED_C);
        end else begin
          if (dly_q != 16'hFFFF) begin
            dly_d = dly_q + 16'd1;
          end
          awready_d = (dly_d >= DLY_C);
        end
      end
      DATA_E: begin
        if (w_hs) begin
          mismatch = (wlast != last_by_cnt);
          mem_we   = !err_q;
          err_d    = err_q | mismatch;
          cnt_d    = cnt_q + 9'd1;
          if (!fixed_q) begin
            idx_d = idx_q + (IDX_W+1)'(1);
          end
          if (wlast || last_by_cnt) begin
            state_d  = RESP_E;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = err_d ? VIP_AXI4_RESP_SLVERR_C : VIP_AXI4_RESP_OKAY_C;
          end
        end
      end
      RESP_E: begin
        if (b_hs) begin
          state_d   = IDLE_E;
          bvalid_d  = 1'b0;
          dly_d     = '0;
          awready_d = (DLY_C == 16'd0);
        end
      end
      default: state_d = IDLE_E;
    endcase
  end

  // Control and handshake registers; reset drops every handshake at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_E;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= VIP_AXI4_RESP_OKAY_C;
      bid     <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
      bid     <= bid_d;
      dly_q   <= dly_d;
    end
  end

  // Burst bookkeeping; always loaded at AW acceptance before it is used.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    len_q   <= len_d;
    cnt_q   <= cnt_d;
    err_q   <= err_d;
    fixed_q <= fixed_d;
  end

  vip_axi4_strb_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH      (MEM_DEPTH_P)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (mem_we),
    .wr_idx  (idx_q[IDX_W-1:0]),
    .wr_data (wdata),
    .wr_strb (wstrb),
    .rd_idx  (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

endmodule
